spi_read_sequencer: RTL

- Transaction sequencer that sits directly upstream of the byte-level SPI shifter.
- Accepts a read request (24-bit address, byte count) from the CPU/memory side.
- Drives chip select and issues one shifter byte per step: READ command 0x03, three address bytes, then dummy 0x00 bytes.
- Returns each received data byte through a valid/ready port with backpressure; chip select is held high for a minimum gap between transactions.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_read_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: read-sequencer state encoding and the byte constants
// understood by both the sequencer and the byte-level shifter.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_ADDR_W = 24;
    localparam int unsigned SPI_REM_W  = 9;

    localparam logic [SPI_BYTE_W-1:0] SPI_CMD_READ   = 8'h03;
    localparam logic [SPI_BYTE_W-1:0] SPI_DUMMY_BYTE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR2,
        ST_ADDR1,
        ST_ADDR0,
        ST_DATA,
        ST_DRAIN,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_read_sequencer.sv
// SPI flash READ sequencer: sends opcode, 24-bit address and dummy bytes through a
// one-byte-at-a-time shifter and returns received bytes on a valid/ready port.
module spi_read_sequencer
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] READ_CMD = SPI_CMD_READ,
    parameter int unsigned           CS_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    input  logic [SPI_BYTE_W-1:0] req_len,
    input  logic                  abort,
    output logic [SPI_BYTE_W-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  cs,
    output logic                  byte_start,
    output logic [SPI_BYTE_W-1:0] byte_tx,
    input  logic                  byte_done,
    input  logic [SPI_BYTE_W-1:0] byte_rx
);

    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

    spi_state_e            state, state_d;
    logic [SPI_ADDR_W-1:0] addr, addr_d;
    logic [SPI_REM_W-1:0]  remaining, remaining_d;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_d;
    logic                  inflight, inflight_d;
    logic                  aborting, aborting_d;
    logic                  req_ready_d, busy_d, cs_d, byte_start_d, rd_valid_d;
    logic [SPI_BYTE_W-1:0] byte_tx_d, rd_data_d;
    logic                  done_ok, abort_hit, start_ok;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            remaining  <= '0;
            gap_cnt    <= '0;
            inflight   <= 1'b0;
            aborting   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            cs         <= 1'b1;
            byte_start <= 1'b0;
            byte_tx    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            state      <= state_d;
            addr       <= addr_d;
            remaining  <= remaining_d;
            gap_cnt    <= gap_cnt_d;
            inflight   <= inflight_d;
            aborting   <= aborting_d;
            req_ready  <= req_ready_d;
            busy       <= busy_d;
            cs         <= cs_d;
            byte_start <= byte_start_d;
            byte_tx    <= byte_tx_d;
            rd_valid   <= rd_valid_d;
            rd_data    <= rd_data_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        addr_d       = addr;
        remaining_d  = remaining;
        gap_cnt_d    = gap_cnt;
        inflight_d   = inflight;
        aborting_d   = aborting;
        req_ready_d  = req_ready;
        busy_d       = busy;
        cs_d         = cs;
        byte_start_d = 1'b0;
        byte_tx_d    = byte_tx;
        rd_valid_d   = rd_valid;
        rd_data_d    = rd_data;

        done_ok   = byte_done && inflight;
        abort_hit = (abort || aborting) && (state != ST_IDLE) && (state != ST_GAP);
        start_ok  = !inflight && (remaining != '0) && (!rd_valid || rd_ready);

        if (done_ok) inflight_d = 1'b0;
        if (rd_valid && rd_ready) rd_valid_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d       = req_addr;
                    remaining_d  = (req_len == '0) ? SPI_REM_W'(256) : {1'b0, req_len};
                    state_d      = ST_CMD;
                    req_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    cs_d         = 1'b0;
                    byte_start_d = 1'b1;
                    byte_tx_d    = READ_CMD;
                    inflight_d   = 1'b1;
                end
            end
            ST_CMD, ST_ADDR2, ST_ADDR1: begin
                if (done_ok) begin
                    byte_start_d = 1'b1;
                    inflight_d   = 1'b1;
                    if (state == ST_CMD) begin
                        state_d   = ST_ADDR2;
                        byte_tx_d = addr[23:16];
                    end else if (state == ST_ADDR2) begin
                        state_d   = ST_ADDR1;
                        byte_tx_d = addr[15:8];
                    end else begin
                        state_d   = ST_ADDR0;
                        byte_tx_d = addr[7:0];
                    end
                end
            end
            ST_ADDR0: begin
                if (done_ok) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (done_ok) begin
                    rd_data_d   = byte_rx;
                    rd_valid_d  = 1'b1;
                    remaining_d = remaining - SPI_REM_W'(1);
                    if (remaining == SPI_REM_W'(1)) state_d = ST_DRAIN;
                end else if (start_ok) begin
                    byte_start_d = 1'b1;
                    byte_tx_d    = SPI_DUMMY_BYTE;
                    inflight_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (rd_valid && rd_ready) begin
                    state_d   = ST_GAP;
                    cs_d      = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides: freeze issue, drop the output byte, finish any byte in flight
        if (abort_hit) begin
            state_d      = state;
            addr_d       = addr;
            remaining_d  = remaining;
            byte_start_d = 1'b0;
            byte_tx_d    = byte_tx;
            rd_valid_d   = 1'b0;
            rd_data_d    = rd_data;
            inflight_d   = inflight && !done_ok;
            aborting_d   = 1'b1;
            if (!inflight || done_ok) begin
                state_d    = ST_GAP;
                cs_d       = 1'b1;
                gap_cnt_d  = GAP_LOAD;
                aborting_d = 1'b0;
            end
        end
    end

endmodule
